// File: rtl/sirv_sram_fill_chk.sv
// SRAM fill / read-back checker driving the uop cmd/rsp channel of the SRAM controller.
// Writes pattern^index over a word range, then optionally reads it back and counts miscompares.
module sirv_sram_fill_chk #(
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int AW       = 32,
  parameter int AW_LSB   = 2,
  parameter int USR_W    = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_OUTS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    cfg_base,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [DW-1:0]    cfg_pattern,
  input  logic             cfg_verify,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    err_addr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             uop_cmd_valid,
  input  logic             uop_cmd_ready,
  output logic             uop_cmd_read,
  output logic [AW-1:0]    uop_cmd_addr,
  output logic [DW-1:0]    uop_cmd_wdata,
  output logic [MW-1:0]    uop_cmd_wmask,
  output logic [USR_W-1:0] uop_cmd_usr,
  input  logic             uop_rsp_valid,
  output logic             uop_rsp_ready,
  input  logic [DW-1:0]    uop_rsp_rdata,
  input  logic [USR_W-1:0] uop_rsp_usr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_WDRAIN = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RDRAIN = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [1:0] MAX_O    = 2'(MAX_OUTS);

  logic [2:0]       state;
  logic [AW-1:0]    base_q;
  logic [DW-1:0]    pat_q;
  logic [CNT_W-1:0] words_q;
  logic             verify_q;
  logic [CNT_W-1:0] iss_idx;
  logic [CNT_W-1:0] rsp_idx;
  logic [1:0]       outs;

  logic issuing, cmd_hs, last_iss, rsp_take, rd_phase, rsp_match, miscmp;
  logic unused_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DW-1:0] expected(input logic [CNT_W-1:0] idx);
    return pat_q ^ DW'(idx);
  endfunction

  // Payload is a pure function of issue index and state, so it holds while stalled.
  assign issuing       = (state == S_WR || state == S_RD) && (iss_idx < words_q) && (outs < MAX_O);
  assign uop_cmd_valid = issuing;
  assign uop_cmd_read  = issuing && (state == S_RD);
  assign uop_cmd_addr  = issuing ? base_q + (AW'(iss_idx) << AW_LSB) : '0;
  assign uop_cmd_wdata = (issuing && state == S_WR) ? expected(iss_idx) : '0;
  assign uop_cmd_wmask = '1;
  assign uop_cmd_usr   = USR_W'(uop_cmd_read);
  assign uop_rsp_ready = 1'b1;
  assign busy          = (state != S_IDLE);

  assign cmd_hs    = issuing && uop_cmd_ready;
  assign last_iss  = cmd_hs && (iss_idx + CNT_W'(1) == words_q);
  assign rsp_take  = uop_rsp_valid && (outs != 2'd0);
  assign rd_phase  = (state == S_RD) || (state == S_RDRAIN);
  assign rsp_match = rsp_take && (uop_rsp_usr[0] == rd_phase);
  assign miscmp    = rsp_match && rd_phase && (uop_rsp_rdata != expected(rsp_idx));
  assign unused_ok = ^uop_rsp_usr;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      base_q <= cfg_base;
      pat_q  <= cfg_pattern;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      words_q  <= '0;
      verify_q <= 1'b0;
      iss_idx  <= '0;
      rsp_idx  <= '0;
      outs     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      done <= (state == S_DONE);
      if (cmd_hs) iss_idx <= iss_idx + CNT_W'(1);
      if (rsp_match) rsp_idx <= rsp_idx + CNT_W'(1);
      case ({cmd_hs, rsp_take})
        2'b10:   outs <= outs + 2'd1;
        2'b01:   outs <= outs - 2'd1;
        default: outs <= outs;
      endcase
      if (miscmp) begin
        err_cnt <= sat_inc(err_cnt);
        if (!err) begin
          err      <= 1'b1;
          err_addr <= base_q + (AW'(rsp_idx) << AW_LSB);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            words_q  <= cfg_words;
            verify_q <= cfg_verify;
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
            iss_idx  <= '0;
            rsp_idx  <= '0;
            outs     <= '0;
            state    <= (cfg_words == '0) ? S_DONE : S_WR;
          end
        end
        S_WR:     if (last_iss) state <= S_WDRAIN;
        S_WDRAIN: begin
          if (outs == 2'd0) begin
            if (verify_q) begin
              state   <= S_RD;
              iss_idx <= '0;
              rsp_idx <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RD:     if (last_iss) state <= S_RDRAIN;
        S_RDRAIN: if (outs == 2'd0) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_sram_fill_chk.sv
// Randomized bench for sirv_sram_fill_chk: a behavioural SRAM with variable response delay
// plus a list-based model of the expected command stream and error results.
module tb_sirv_sram_fill_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_words = '0;
  logic [31:0] cfg_pattern = '0;
  logic        cfg_verify = 1'b0;
  logic        busy, done, err;
  logic [31:0] err_addr;
  logic [15:0] err_cnt;
  logic        uop_cmd_valid;
  logic        uop_cmd_ready = 1'b1;
  logic        uop_cmd_read;
  logic [31:0] uop_cmd_addr, uop_cmd_wdata;
  logic [3:0]  uop_cmd_wmask;
  logic [2:0]  uop_cmd_usr;
  logic        uop_rsp_valid = 1'b0;
  logic        uop_rsp_ready;
  logic [31:0] uop_rsp_rdata = '0;
  logic [2:0]  uop_rsp_usr = '0;

  sirv_sram_fill_chk dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_pattern(cfg_pattern), .cfg_verify(cfg_verify),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .err_cnt(err_cnt),
    .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready), .uop_cmd_read(uop_cmd_read),
    .uop_cmd_addr(uop_cmd_addr), .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
    .uop_cmd_usr(uop_cmd_usr), .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
    .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_usr(uop_rsp_usr)
  );

  always #5 clk = ~clk;

  typedef struct { logic rd; logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { int due; logic [31:0] data; logic [2:0] usr; } rsp_t;

  cmd_t        exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [logic [31:0]];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          model_outs = 0;
  int          peak = 0;
  int          done_cnt = 0;
  int          rd_hs = 0;
  bit          stall_mode = 0;
  bit          stalled_prev = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic [31:0] cur_base;
  logic [63:0] cur_corrupt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_valid", 64'(uop_cmd_valid), 64'd0);
    chk("rst_read", 64'(uop_cmd_read), 64'd0);
    chk("rst_addr", 64'(uop_cmd_addr), 64'd0);
    chk("rst_wdata", 64'(uop_cmd_wdata), 64'd0);
    chk("rst_usr", 64'(uop_cmd_usr), 64'd0);
    chk("rst_wmask", 64'(uop_cmd_wmask), 64'hF);
    chk("rst_rsp_ready", 64'(uop_rsp_ready), 64'd1);
  endtask

  // One clock of the SRAM model: inputs change at negedge, DUT samples them at posedge.
  task automatic step();
    rsp_t        r;
    cmd_t        c;
    logic [31:0] d;
    int          idx;
    int          due;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    if (done) done_cnt++;
    if (stalled_prev) begin
      chk("stall_valid", 64'(uop_cmd_valid), 64'd1);
      chk("stall_addr", 64'(uop_cmd_addr), 64'(prev_addr));
      chk("stall_wdata", 64'(uop_cmd_wdata), 64'(prev_wdata));
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      uop_rsp_valid = 1'b1;
      uop_rsp_rdata = r.data;
      uop_rsp_usr   = r.usr;
      if (model_outs > 0) model_outs--;
    end else begin
      uop_rsp_valid = 1'b0;
      uop_rsp_rdata = $urandom;
      uop_rsp_usr   = 3'($urandom);
    end
    uop_cmd_ready = stall_mode ? ((cyc % 2) == 1) : 1'b1;
    if (rst_n && uop_cmd_valid && uop_cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_cmd", 64'd1, 64'd0);
      end else begin
        c = exp_q.pop_front();
        chk("cmd_read", 64'(uop_cmd_read), 64'(c.rd));
        chk("cmd_addr", 64'(uop_cmd_addr), 64'(c.addr));
        chk("cmd_usr", 64'(uop_cmd_usr), 64'(c.rd));
        chk("cmd_wmask", 64'(uop_cmd_wmask), 64'hF);
        if (!c.rd) chk("cmd_wdata", 64'(uop_cmd_wdata), 64'(c.data));
      end
      d = '0;
      if (!uop_cmd_read) begin
        mem[uop_cmd_addr] = uop_cmd_wdata;
      end else begin
        rd_hs++;
        if (mem.exists(uop_cmd_addr)) d = mem[uop_cmd_addr];
        idx = int'((uop_cmd_addr - cur_base) >> 2);
        if (idx < 64 && cur_corrupt[idx]) d = d ^ 32'd1;
      end
      due = cyc + (stall_mode ? int'($urandom_range(4, 2)) : 1);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_q.push_back('{due, d, uop_cmd_usr});
      model_outs++;
      if (model_outs > peak) peak = model_outs;
    end
    stalled_prev = uop_cmd_valid && !uop_cmd_ready;
    prev_addr    = uop_cmd_addr;
    prev_wdata   = uop_cmd_wdata;
  endtask

  task automatic run_op(input logic [31:0] base, input int n, input logic [31:0] pat, input bit ver,
                        input logic [63:0] corrupt, input bit stall, input int dup_at, input int abort_rd);
    int          k;
    bit          seen;
    int          first;
    int          ecnt;
    logic [31:0] eaddr;
    stall_mode  = stall;
    cur_base    = base;
    cur_corrupt = corrupt;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, base + 32'(i) * 32'd4, pat ^ 32'(i)});
    if (ver) for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, base + 32'(i) * 32'd4, 32'd0});
    first = -1;
    ecnt  = 0;
    for (int i = 0; i < n && i < 64; i++) begin
      if (ver && corrupt[i]) begin
        ecnt++;
        if (first < 0) first = i;
      end
    end
    eaddr = (first < 0) ? 32'd0 : base + 32'(first) * 32'd4;
    done_cnt = 0;
    rd_hs    = 0;
    peak     = 0;
    step();
    cfg_base    = base;
    cfg_words   = 16'(n);
    cfg_pattern = pat;
    cfg_verify  = ver;
    start       = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 40 * n + 50) begin
      step();
      k++;
      if (k == 1) begin
        chk("busy_rise", 64'(busy), 64'd1);
        chk("first_valid", 64'(uop_cmd_valid), 64'(n != 0));
      end
      if (done) begin
        seen = 1;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (k == dup_at) begin
        cfg_words = 16'd5;
        cfg_base  = base + 32'h40;
        start     = 1'b1;
      end
      if (abort_rd > 0 && rd_hs >= abort_rd) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        step();
        rst_n        = 1'b1;
        model_outs   = 0;
        stalled_prev = 0;
        repeat (6) step();
        exp_q.delete();
        return;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) step();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("err", 64'(err), 64'(ecnt != 0));
    chk("err_addr", 64'(err_addr), 64'(eaddr));
    chk("err_cnt", 64'(err_cnt), 64'(ecnt));
    chk("cmds_left", 64'(exp_q.size()), 64'd0);
    chk("max_outs", 64'(peak <= 2), 64'd1);
  endtask

  initial begin
    repeat (3) step();
    chk_reset_outputs();
    rst_n = 1'b1;
    step();
    run_op(32'h100, 4, 32'hA5A5_0000, 1'b0, 64'd0, 1'b0, 0, 0);
    run_op(32'h1000 + ($urandom & 32'hFF0), 8, $urandom, 1'b1, 64'd0, 1'b0, 0, 0);
    run_op(32'h200, 8, $urandom, 1'b1, 64'h28, 1'b0, 0, 0);
    run_op(32'h400, 10, $urandom, 1'b1, 64'd0, 1'b1, 0, 0);
    run_op(32'h400, 10, $urandom, 1'b1, 64'h204, 1'b1, 0, 0);
    run_op(32'h300, 0, $urandom, 1'b1, 64'd0, 1'b0, 1, 0);
    run_op(32'h600, 8, $urandom, 1'b1, 64'd0, 1'b0, 3, 0);
    run_op(32'h800, 6, $urandom, 1'b1, 64'd0, 1'b0, 0, 2);
    run_op(32'h900, 2, $urandom, 1'b1, 64'd0, 1'b0, 0, 0);
    run_op(32'hFFFF_FFF8, 6, $urandom, 1'b1, 64'h10, 1'b0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      run_op(($urandom & 32'hFFFF_FFFC), int'($urandom_range(12, 1)), $urandom, 1'b1,
             {32'd0, 32'($urandom) & 32'hFFF}, 1'($urandom), 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sirv_sram_fill_chk.md
# sirv_sram_fill_chk

Command-side initiator for the single-cycle SRAM controller's uop cmd/rsp channel. On a start pulse it fills a word range of the TCM/SRAM with a deterministic pattern, then optionally reads the range back and checks it. Sits beside the core's TCM access path (behind an arbiter) for boot-time zeroing and memory self-test.

## Interface
Parameters:
- DW, 32, data width
- MW, 4, write-mask width (DW/8)
- AW, 32, byte-address width
- AW_LSB, 2, log2 of bytes per word; word i address = base + (i << AW_LSB)
- USR_W, 3, user tag width, at least 1
- CNT_W, 16, word-count width
- MAX_OUTS, 2, maximum outstanding commands, 1..3

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start request; ignored while busy
- cfg_base  in  AW  byte base address, sampled at start
- cfg_words  in  CNT_W  number of words, sampled at start
- cfg_pattern  in  DW  seed pattern, sampled at start
- cfg_verify  in  1  1 = fill then read-check, sampled at start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: at least one read miscompare; cleared at start
- err_addr  out  AW  byte address of the first miscompare
- err_cnt  out  CNT_W  miscompare count, saturating at all-ones
- uop_cmd_valid  out  1  command valid
- uop_cmd_ready  in  1  command ready
- uop_cmd_read  out  1  1 = read, 0 = write
- uop_cmd_addr  out  AW  byte address
- uop_cmd_wdata  out  DW  write data
- uop_cmd_wmask  out  MW  always all-ones
- uop_cmd_usr  out  USR_W  bit0 = read flag; other bits 0
- uop_rsp_valid  in  1  response valid
- uop_rsp_ready  out  1  always 1
- uop_rsp_rdata  in  DW  read data
- uop_rsp_usr  in  USR_W  returned tag

## Operation
- Expected data for word i is cfg_pattern XOR i, with i zero-extended or truncated to DW.
- The FSM has the states IDLE, WR, WDRAIN, RD, RDRAIN and DONE.
- IDLE:
  - On start, capture cfg_*, clear err, err_addr and err_cnt, and zero the issue and response indices and the outstanding counter.
  - Go to WR. If cfg_words == 0, go to DONE instead.
- WR:
  - Assert uop_cmd_valid with read=0 while issue index < cfg_words and outstanding < MAX_OUTS.
  - Each cmd handshake increments the issue index.
  - When the last write handshakes, go to WDRAIN.
- WDRAIN: when outstanding == 0, go to RD if verify is set, otherwise DONE. Reset both indices on entry to RD.
- RD:
  - Same issue rule as WR, with read=1 and usr[0]=1.
  - Each rsp compares rdata to expected(response index), then increments the response index.
  - After the last read handshakes, go to RDRAIN.
- RDRAIN: when outstanding == 0, go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Outstanding counter: +1 on a cmd handshake, -1 on an rsp; both in the same cycle leaves it unchanged.
- Miscompare:
  - err_cnt increments, saturating.
  - On the first miscompare only, err <= 1 and err_addr <= base + (response index << AW_LSB).
- A response whose usr[0] does not match the current phase is not compared, but it still decrements the outstanding counter.
- A response arriving while outstanding == 0 is ignored.
- uop_cmd_addr and wdata stay stable while valid && !ready.
- Address arithmetic wraps modulo 2^AW.

## Timing
- Reset values:
  - busy=0, done=0, err=0, err_addr=0, err_cnt=0.
  - uop_cmd_valid=0, cmd_read=0, addr=0, wdata=0, usr=0.
  - uop_cmd_wmask is all-ones and uop_rsp_ready=1 at all times.
- start accepted in cycle 0:
  - busy=1 from cycle 1.
  - First uop_cmd_valid in cycle 1.
- Against the 1-cycle controller with ready held high:
  - One command per cycle, and N writes occupy cycles 1..N.
  - WDRAIN ends after the final response in cycle N+1.
  - Reads follow with the same cadence.
- done is asserted in the cycle after the FSM enters DONE, and busy falls in the same cycle done is high.
- Completion latency with verify and no stalls is about 2N+4 cycles.
- start asserted while busy, or in the DONE cycle, is dropped.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. Any response to an in-flight command is then ignored.

## Test plan
- Fill only: base=0x100, words=4, pattern=0xA5A5_0000, verify=0.
  - Required: writes to 0x100/104/108/10C with data 0xA5A5_0000..0xA5A5_0003.
  - done pulse, err=0.
- Fill and verify against a model: words=8, verify=1.
  - Required: 8 writes, then 8 reads, err=0, err_cnt=0, done exactly once.
- Injected corruption: model flips bit 0 of words 3 and 5 on read; base=0x200.
  - Required: err=1, err_addr=0x20C, err_cnt=2.
- Backpressure: cmd_ready toggles 1/0, and responses are delayed so that MAX_OUTS=2 limits issue.
  - Required: outstanding never exceeds 2, cmd payload stable while stalled, result identical to no-stall.
- words=0, plus start pulsed while busy:
  - words=0 gives done one cycle after entering DONE, with no commands issued.
  - The second start is ignored.
- Reset asserted in the RD phase:
  - Required: all outputs at reset values.
  - A subsequent start with words=2 completes cleanly.
